conv1_calc: RTL

- Compute stage directly downstream of the conv1 3x3 window buffer.
- Consumes one binary 3x3 window per valid beat and computes NUM_FILT signed dot products with programmable weights plus bias.
- Applies ReLU with unsigned saturation and emits one feature-map pixel vector per window.
- Fixed 3-stage non-stallable pipeline; tracks output position and flags the end of each feature map.

---
 rtl/conv1_calc_if.sv | 43 ++++
 rtl/conv1_calc.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/conv1_calc_if.sv
// conv1_calc_if: bundle between the conv1 window buffer / weight loader (master)
// and the conv1_calc compute stage (slave).
//   w_load/w_addr/w_data : weight store write port (addr = filt*10 + k, k 9 = bias)
//   valid_in/pixel_0..8  : one binary 3x3 window per valid beat, row-major
//   valid_out/conv_out   : one ReLU'd pixel vector per window, channel f at [f*OUT_BITS +: OUT_BITS]
//   out_x/out_y          : feature-map position of the current output beat
//   frame_done           : pulse on the last pixel of a feature map
interface conv1_calc_if #(
    parameter int unsigned NUM_FILT = 4,
    parameter int unsigned W_BITS   = 8,
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned OUT_W    = 26,
    parameter int unsigned OUT_H    = 26
);
    localparam int unsigned AddrW = $clog2(NUM_FILT * 10);
    localparam int unsigned XW    = $clog2(OUT_W);
    localparam int unsigned YW    = $clog2(OUT_H);

    logic                         w_load;
    logic [AddrW-1:0]             w_addr;
    logic [W_BITS-1:0]            w_data;
    logic                         valid_in;
    logic                         pixel_0, pixel_1, pixel_2;
    logic                         pixel_3, pixel_4, pixel_5;
    logic                         pixel_6, pixel_7, pixel_8;
    logic                         valid_out;
    logic [NUM_FILT*OUT_BITS-1:0] conv_out;
    logic [XW-1:0]                out_x;
    logic [YW-1:0]                out_y;
    logic                         frame_done;

    modport master (
        output w_load, w_addr, w_data, valid_in,
        output pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8,
        input  valid_out, conv_out, out_x, out_y, frame_done
    );

    modport slave (
        input  w_load, w_addr, w_data, valid_in,
        input  pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7, pixel_8,
        output valid_out, conv_out, out_x, out_y, frame_done
    );
endinterface

// File: rtl/conv1_calc.sv
// conv1_calc: binary 3x3 window x programmable signed weights + bias per filter,
// ReLU with unsigned saturation, fixed 3-cycle non-stallable pipeline.
//   clk    : clock
//   rst    : synchronous active-high reset (clears weights, pipeline and position)
//   bus_io : conv1_calc_if slave (weight write port, window input, result output)
module conv1_calc #(
    parameter int unsigned NUM_FILT = 4,
    parameter int unsigned W_BITS   = 8,
    parameter int unsigned OUT_BITS = 8,
    parameter int unsigned OUT_W    = 26,
    parameter int unsigned OUT_H    = 26
) (
    input  logic        clk,
    input  logic        rst,
    conv1_calc_if.slave bus_io
);
    localparam int unsigned NumW  = NUM_FILT * 10;
    localparam int unsigned AddrW = $clog2(NumW);
    localparam int unsigned Acc   = W_BITS + 4;
    localparam int unsigned XW    = $clog2(OUT_W);
    localparam int unsigned YW    = $clog2(OUT_H);

    // Sign-extend a weight to accumulator width.
    function automatic logic [Acc-1:0] sext(input logic [W_BITS-1:0] w);
        return {{(Acc - W_BITS){w[W_BITS-1]}}, w};
    endfunction

    logic [8:0] pix;
    assign pix = {bus_io.pixel_8, bus_io.pixel_7, bus_io.pixel_6,
                  bus_io.pixel_5, bus_io.pixel_4, bus_io.pixel_3,
                  bus_io.pixel_2, bus_io.pixel_1, bus_io.pixel_0};

    // Weight store
    logic [NumW-1:0][W_BITS-1:0] weights_q, weights_d;

    for (genvar i = 0; i < NumW; i++) begin : g_wr
        assign weights_d[i] = (bus_io.w_load && bus_io.w_addr == AddrW'(i)) ?
                              bus_io.w_data : weights_q[i];
    end

    // Pipeline datapath. Bias is latched alongside the row sums in S1 so a window always
    // sees one consistent weight set, the one present on the cycle it was accepted.
    logic [NUM_FILT-1:0][2:0][Acc-1:0] s1_row_q, s1_row_d;
    logic [NUM_FILT-1:0][Acc-1:0]      s1_bias_q, s1_bias_d;
    logic [NUM_FILT-1:0][Acc-1:0]      s2_sum_q, s2_sum_d;
    logic [NUM_FILT-1:0][OUT_BITS-1:0] relu;
    logic                              s1_valid_q, s2_valid_q;

    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        for (genvar r = 0; r < 3; r++) begin : g_row
            // Binary pixels turn each product into a weight-or-zero select.
            assign s1_row_d[f][r] =
                (pix[3*r]   ? sext(weights_q[f*10 + 3*r])   : '0) +
                (pix[3*r+1] ? sext(weights_q[f*10 + 3*r+1]) : '0) +
                (pix[3*r+2] ? sext(weights_q[f*10 + 3*r+2]) : '0);
        end
        assign s1_bias_d[f] = sext(weights_q[f*10 + 9]);
        assign s2_sum_d[f]  = s1_row_q[f][0] + s1_row_q[f][1] + s1_row_q[f][2] + s1_bias_q[f];

        always_comb begin
            if (s2_sum_q[f][Acc-1]) begin
                relu[f] = '0;
            end else if (|s2_sum_q[f][Acc-2:OUT_BITS]) begin
                relu[f] = '1;
            end else begin
                relu[f] = s2_sum_q[f][OUT_BITS-1:0];
            end
        end
    end

    // Output position tracking
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          last_pos;

    assign last_pos = (cx_q == XW'(OUT_W - 1)) && (cy_q == YW'(OUT_H - 1));

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (s2_valid_q) begin
            if (cx_q == XW'(OUT_W - 1)) begin
                cx_d = '0;
                cy_d = (cy_q == YW'(OUT_H - 1)) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    // Output stage: everything except valid_out is forced to zero on bubbles.
    logic                         valid_out_q, frame_done_q;
    logic [NUM_FILT*OUT_BITS-1:0] conv_out_q, conv_out_d;
    logic [XW-1:0]                out_x_q, out_x_d;
    logic [YW-1:0]                out_y_q, out_y_d;

    always_comb begin
        conv_out_d = s2_valid_q ? relu : '0;
        out_x_d    = s2_valid_q ? cx_q : '0;
        out_y_d    = s2_valid_q ? cy_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weights_q    <= '0;
            s1_row_q     <= '0;
            s1_bias_q    <= '0;
            s1_valid_q   <= 1'b0;
            s2_sum_q     <= '0;
            s2_valid_q   <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            valid_out_q  <= 1'b0;
            conv_out_q   <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            weights_q    <= weights_d;
            s1_row_q     <= s1_row_d;
            s1_bias_q    <= s1_bias_d;
            s1_valid_q   <= bus_io.valid_in;
            s2_sum_q     <= s2_sum_d;
            s2_valid_q   <= s1_valid_q;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            valid_out_q  <= s2_valid_q;
            conv_out_q   <= conv_out_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            frame_done_q <= s2_valid_q && last_pos;
        end
    end

    assign bus_io.valid_out  = valid_out_q;
    assign bus_io.conv_out   = conv_out_q;
    assign bus_io.out_x      = out_x_q;
    assign bus_io.out_y      = out_y_q;
    assign bus_io.frame_done = frame_done_q;
endmodule
